aline_sample_buffer: RTL and testbench

Ping-pong A-line capture buffer that sits directly downstream of the per-sweep sample address counter. It writes each addressed ADC sample into one of two banks of NSAMPLES words. When the final sample of an A-line lands, that bank is committed and streamed out in address order over a valid/ready interface to the host transfer path. Capture of the next sweep runs in parallel in the other bank.

---
 rtl/sss_acq_pkg.sv | 20 ++
 rtl/aline_sample_buffer_if.sv | 36 +++
 rtl/aline_bank_ram.sv | 33 +++
 rtl/aline_sample_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_aline_sample_buffer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sss_acq_pkg.sv
// Shared acquisition definitions for the A-line capture path.
// Holds the default sweep geometry (also used by the sample address counter)
// and the state types of the capture buffer's writer and reader FSMs.
package sss_acq_pkg;

    localparam int NSAMPLES = 1170;   // samples per A-line
    localparam int ADDR_W   = 11;     // sample address width
    localparam int DATA_W   = 14;     // ADC sample width

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rd_state_t;

endpackage

// File: rtl/aline_sample_buffer_if.sv
// Streaming output bus of the A-line capture buffer.
//   out_data  : streamed sample
//   out_valid : out_data valid
//   out_ready : consumer accepts when out_valid && out_ready
//   out_last  : marks the final word of an A-line
//   out_bank  : bank currently streaming
// master = buffer side, slave = host transfer side.
interface aline_sample_buffer_if
    import sss_acq_pkg::*;
#(
    parameter int DW = DATA_W
) ();

    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          out_bank;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_bank,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_bank,
        output out_ready
    );

endinterface

// File: rtl/aline_bank_ram.sv
// Two-bank sample store for the A-line capture buffer.
// Simple dual-port RAM, depth 2*2^AW, addressed as {bank, addr}.
//   clock   : single clock for both ports
//   wr_en   : write wr_data at wr_addr
//   rd_en   : load rd_data from rd_addr (one cycle read latency)
// Contents are never reset.
module aline_bank_ram
    import sss_acq_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW:0]   rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**(AW+1)];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/aline_sample_buffer.sv
// Ping-pong A-line capture buffer.
// Captures addressed ADC samples into one of two banks; a bank whose final
// address has been written is committed and streamed out in address order
// while the next sweep fills the other bank.
//   clock, sclr        : clock, async active-high reset
//   line_start         : sweep trigger pulse
//   sample_valid/addr/data : addressed sample from the address counter
//   out_if (master)    : valid/ready stream of committed lines
//   overrun            : sticky, a line was dropped (no free bank)
//   short_line         : sticky, a line restarted before completion
//   lines_done         : count of fully streamed lines (wraps)
//
// state     | meaning
// W_IDLE    | writer waiting for line_start with a free bank
// W_FILL    | writer capturing samples into wr_bank
// R_IDLE    | reader waiting for full[rd_bank]
// R_STREAM  | reader issuing RAM reads of rd_bank, addresses 0..NSAMPLES-1
module aline_sample_buffer
    import sss_acq_pkg::*;
#(
    parameter int NSAMPLES = sss_acq_pkg::NSAMPLES,
    parameter int ADDR_W   = sss_acq_pkg::ADDR_W,
    parameter int DATA_W   = sss_acq_pkg::DATA_W
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 line_start,
    input  logic                 sample_valid,
    input  logic [ADDR_W-1:0]    sample_addr,
    input  logic [DATA_W-1:0]    sample_data,
    aline_sample_buffer_if.master out_if,
    output logic                 overrun,
    output logic                 short_line,
    output logic [15:0]          lines_done
);

    localparam logic [ADDR_W:0] N_EXT     = (ADDR_W+1)'(NSAMPLES);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(NSAMPLES - 1);

    wr_state_t         wr_state;
    rd_state_t         rd_state;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_bank;
    logic              rd_bank;

    logic [ADDR_W:0]   samp_ext;
    logic              wr_en;
    logic              commit;

    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   rd_word;
    logic              issue_idle;
    logic              issue_strm;
    logic              rd_en;
    logic              issue_last;
    logic [DATA_W-1:0] rd_data;
    logic              rd_pend;
    logic              rd_pend_last;

    logic [DATA_W-1:0] q_data [2];
    logic              q_last [2];
    logic [1:0]        q_cnt;
    logic [2:0]        occ;
    logic              room;
    logic              pop;
    logic              release_bank;

    // ---------------- writer ----------------
    assign samp_ext = {1'b0, sample_addr};
    // A sample coinciding with line_start belongs to no line and is dropped.
    assign wr_en  = (wr_state == W_FILL) && !line_start && sample_valid && (samp_ext < N_EXT);
    assign commit = wr_en && (samp_ext == LAST_ADDR);

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            wr_state   <= W_IDLE;
            wr_bank    <= 1'b0;
            overrun    <= 1'b0;
            short_line <= 1'b0;
        end else begin
            unique case (wr_state)
                W_IDLE: begin
                    if (line_start) begin
                        if (full[wr_bank]) begin
                            overrun <= 1'b1;
                        end else begin
                            wr_state <= W_FILL;
                        end
                    end
                end
                W_FILL: begin
                    if (line_start) begin
                        // Partial line abandoned; refill the same bank.
                        short_line <= 1'b1;
                    end else if (commit) begin
                        wr_bank  <= ~wr_bank;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Commit and release always target different banks, so both may land together.
    always_comb begin
        full_nxt = full;
        if (release_bank) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (commit) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    // ---------------- RAM ----------------
    aline_bank_ram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, sample_addr}),
        .wr_data (sample_data),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank, rd_word[ADDR_W-1:0]}),
        .rd_data (rd_data)
    );

    // ---------------- reader + skid stage ----------------
    assign pop          = (q_cnt != 2'd0) && out_if.out_ready;
    assign release_bank = pop && q_last[0];

    // Words held or in flight after this cycle; a new read is allowed only if
    // its data is guaranteed a skid slot even if the consumer stalls.
    assign occ  = {1'b0, q_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    assign room = occ < 3'd2;

    // Word 0 is issued straight from R_IDLE to save a cycle of start latency.
    assign issue_idle = (rd_state == R_IDLE) && full[rd_bank] && room;
    assign issue_strm = (rd_state == R_STREAM) && (ptr != N_EXT) && room;
    assign rd_en      = issue_idle || issue_strm;
    assign rd_word    = issue_idle ? '0 : ptr;
    assign issue_last = (rd_word == LAST_ADDR);

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            rd_state     <= R_IDLE;
            rd_bank      <= 1'b0;
            ptr          <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            q_data[0]    <= '0;
            q_data[1]    <= '0;
            q_last[0]    <= 1'b0;
            q_last[1]    <= 1'b0;
            q_cnt        <= 2'd0;
            lines_done   <= 16'd0;
        end else begin
            rd_pend      <= rd_en;
            rd_pend_last <= rd_en && issue_last;

            if (issue_idle) begin
                rd_state <= R_STREAM;
                ptr      <= (ADDR_W+1)'(1);
            end else if (issue_strm) begin
                ptr <= ptr + 1'b1;
            end

            if (release_bank) begin
                rd_state   <= R_IDLE;
                rd_bank    <= ~rd_bank;
                lines_done <= lines_done + 16'd1;
            end

            unique case ({pop, rd_pend})
                2'b01: begin
                    if (q_cnt == 2'd0) begin
                        q_data[0] <= rd_data;
                        q_last[0] <= rd_pend_last;
                    end else begin
                        q_data[1] <= rd_data;
                        q_last[1] <= rd_pend_last;
                    end
                    q_cnt <= q_cnt + 2'd1;
                end
                2'b10: begin
                    q_data[0] <= q_data[1];
                    q_last[0] <= q_last[1];
                    q_cnt     <= q_cnt - 2'd1;
                end
                2'b11: begin
                    if (q_cnt == 2'd1) begin
                        q_data[0] <= rd_data;
                        q_last[0] <= rd_pend_last;
                    end else begin
                        q_data[0] <= q_data[1];
                        q_last[0] <= q_last[1];
                        q_data[1] <= rd_data;
                        q_last[1] <= rd_pend_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_if.out_valid = (q_cnt != 2'd0);
    assign out_if.out_data  = q_data[0];
    assign out_if.out_last  = (q_cnt != 2'd0) && q_last[0];
    assign out_if.out_bank  = rd_bank;

endmodule

// File: tb/tb_aline_sample_buffer.sv
// Self-checking bench for aline_sample_buffer: randomized sample gaps,
// out-of-range addresses, data and backpressure, scored against a line-level
// model (banks alternate per committed line, lines stream whole and in order).
module tb_aline_sample_buffer;
    import sss_acq_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              bank;
    } word_t;

    logic                clock = 1'b0;
    logic                sclr;
    logic                line_start;
    logic                sample_valid;
    logic [ADDR_W-1:0]   sample_addr;
    logic [DATA_W-1:0]   sample_data;
    logic                overrun;
    logic                short_line;
    logic [15:0]         lines_done;

    aline_sample_buffer_if #(.DW(DATA_W)) bus ();

    aline_sample_buffer #(
        .NSAMPLES (NSAMPLES),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clock        (clock),
        .sclr         (sclr),
        .line_start   (line_start),
        .sample_valid (sample_valid),
        .sample_addr  (sample_addr),
        .sample_data  (sample_data),
        .out_if       (bus.master),
        .overrun      (overrun),
        .short_line   (short_line),
        .lines_done   (lines_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    word_t             exp_q[$];
    logic [DATA_W-1:0] line_buf [NSAMPLES];
    int                committed;
    int                streamed_lines;
    int                stream_words;
    bit                m_filling;
    bit                m_overrun;
    bit                m_short;
    bit                bp_mode;
    bit                ready_lvl;

    function automatic void model_start_line();
        if (m_filling) m_short = 1'b1;
        else if (committed - streamed_lines < 2) m_filling = 1'b1;
        else m_overrun = 1'b1;
    endfunction

    function automatic void model_sample(input int addr, input logic [DATA_W-1:0] data);
        if (m_filling && addr < NSAMPLES) begin
            line_buf[addr] = data;
            if (addr == NSAMPLES - 1) begin
                for (int i = 0; i < NSAMPLES; i++)
                    exp_q.push_back('{data: line_buf[i], last: (i == NSAMPLES - 1), bank: committed[0]});
                committed++;
                m_filling = 1'b0;
            end
        end
    endfunction

    // ---------------- monitor ----------------
    bit    hold;
    word_t held;

    always @(negedge clock) begin
        if (sclr) begin
            hold           = 1'b0;
            stream_words   = 0;
            streamed_lines = 0;
            exp_q.delete();
        end else begin
            if (hold) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_word", 32'({bus.out_data, bus.out_last, bus.out_bank}), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 32'(bus.out_valid), 32'd0);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("data", 32'(bus.out_data), 32'(w.data));
                    check("last", 32'(bus.out_last), 32'(w.last));
                    check("bank", 32'(bus.out_bank), 32'(w.bank));
                    if (w.last) streamed_lines++;
                end
                stream_words++;
            end
            hold = bus.out_valid && !bus.out_ready;
            held = '{data: bus.out_data, last: bus.out_last, bank: bus.out_bank};
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bus.out_ready = bp_mode ? ($urandom_range(0, 1) == 1) : ready_lvl;
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_sample(input bit v, input int addr, input logic [DATA_W-1:0] data);
        line_start   = 1'b0;
        sample_valid = v;
        sample_addr  = addr[ADDR_W-1:0];
        sample_data  = data;
        if (v) model_sample(addr, data);
        tick();
    endtask

    // Line start carries a stray sample at the last address; it must not commit.
    task automatic drive_line(input bit rnd, input int base, input bit noise, input int last_addr);
        logic [DATA_W-1:0] d;
        line_start   = 1'b1;
        sample_valid = 1'b1;
        sample_addr  = ADDR_W'(NSAMPLES - 1);
        sample_data  = DATA_W'($urandom);
        model_start_line();
        tick();
        for (int a = 0; a <= last_addr; a++) begin
            if (noise && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    drive_sample(1'b1, NSAMPLES + $urandom_range(0, (1 << ADDR_W) - NSAMPLES - 1), DATA_W'($urandom));
                else
                    drive_sample(1'b0, 0, '0);
            end
            d = rnd ? DATA_W'($urandom) : DATA_W'(base + a);
            drive_sample(1'b1, a, d);
        end
        sample_valid = 1'b0;
        line_start   = 1'b0;
    endtask

    task automatic reset_dut();
        sclr         = 1'b1;
        line_start   = 1'b0;
        sample_valid = 1'b0;
        tick();
        tick();
        committed = 0;
        m_filling = 1'b0;
        m_overrun = 1'b0;
        m_short   = 1'b0;
        sclr      = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_last"},  32'(bus.out_last),  32'd0);
        check({tag, "_bank"},  32'(bus.out_bank),  32'd0);
        check({tag, "_data"},  32'(bus.out_data),  32'd0);
        check({tag, "_ovr"},   32'(overrun),       32'd0);
        check({tag, "_short"}, 32'(short_line),    32'd0);
        check({tag, "_lines"}, 32'(lines_done),    32'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 10000) begin
            tick();
            n++;
        end
        tick();
        tick();
        check({tag, "_left"},  32'(exp_q.size()), 32'd0);
        check({tag, "_lines"}, 32'(lines_done),   32'(committed));
        check({tag, "_ovr"},   32'(overrun),      32'(m_overrun));
        check({tag, "_short"}, 32'(short_line),   32'(m_short));
    endtask

    task automatic wait_free_bank();
        int n = 0;
        while (committed - streamed_lines >= 2 && n < 10000) begin
            tick();
            n++;
        end
        check("free_bank_wait", 32'(committed - streamed_lines < 2), 32'd1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int lat;
        bp_mode      = 1'b0;
        ready_lvl    = 1'b1;
        sclr         = 1'b1;
        line_start   = 1'b0;
        sample_valid = 1'b0;
        sample_addr  = '0;
        sample_data  = '0;
        committed    = 0;
        m_filling    = 1'b0;
        m_overrun    = 1'b0;
        m_short      = 1'b0;
        repeat (3) tick();
        sclr = 1'b0;
        tick();
        check_reset_outputs("rst");

        // Single line, data = addr, plus start latency
        drive_line(1'b0, 0, 1'b0, NSAMPLES - 1);
        lat = 0;
        while (lat < 20) begin
            @(negedge clock);
            if (bus.out_valid) break;
            lat++;
        end
        check("first_valid_lat", 32'(lat), 32'd2);
        drain("single");

        // Ping-pong: three lines, banks 0,1,0
        reset_dut();
        for (int l = 0; l < 3; l++) begin
            repeat (4) tick();
            drive_line(1'b0, l * 2048, 1'b0, NSAMPLES - 1);
        end
        drain("pingpong");

        // Short line then a full noisy line
        reset_dut();
        drive_line(1'b1, 0, 1'b0, 499);
        drive_line(1'b1, 0, 1'b1, NSAMPLES - 1);
        drain("short");

        // Overrun with the consumer stalled
        reset_dut();
        ready_lvl = 1'b0;
        tick();
        for (int l = 0; l < 3; l++) drive_line(1'b1, 0, 1'b1, NSAMPLES - 1);
        repeat (4) tick();
        check("ovr_flag", 32'(overrun), 32'(m_overrun));
        check("ovr_stalled", 32'(lines_done), 32'd0);
        ready_lvl = 1'b1;
        drain("overrun");

        // Random backpressure, three lines
        reset_dut();
        bp_mode = 1'b1;
        for (int l = 0; l < 3; l++) begin
            wait_free_bank();
            repeat (4) tick();
            drive_line(1'b1, 0, 1'b1, NSAMPLES - 1);
        end
        drain("backpressure");
        bp_mode = 1'b0;

        // Reset at word 600 of a stream, then a clean line from bank 0
        reset_dut();
        drive_line(1'b0, 0, 1'b0, NSAMPLES - 1);
        lat = 0;
        while (stream_words < 600 && lat < 5000) begin
            tick();
            lat++;
        end
        check("midrst_reach", 32'(stream_words >= 600), 32'd1);
        sclr = 1'b1;
        #2;
        check_reset_outputs("midrst");
        reset_dut();
        check_reset_outputs("postrst");
        drive_line(1'b0, 3 * 2048, 1'b0, NSAMPLES - 1);
        drain("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
